// File: rtl/meduram_arb_pkg.sv
// Shared definitions for the MEDURAM port arbiter: requester-id sizing and
// the tag that follows each accepted read through the RAM latency.
package meduram_arb_pkg;

  localparam int TAG_ID_WIDTH = 8;

  function automatic int idWidth(input int nReq);
    return (nReq <= 2) ? 1 : $clog2(nReq);
  endfunction

  typedef struct packed {
    logic                    en;
    logic [TAG_ID_WIDTH-1:0] id;
  } tag_t;

endpackage

// File: rtl/meduram_rr_pick2.sv
// Combinational two-winner round-robin picker. Winner A is the first request
// at or after the pointer; winner B is the next one after A, unless masked off.
module meduram_rr_pick2 #(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [N_REQ-1:0]    i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  input  logic [N_REQ-1:0]    i_blockB,
  output logic                o_aValid,
  output logic [ID_WIDTH-1:0] o_aIdx,
  output logic                o_bValid,
  output logic [ID_WIDTH-1:0] o_bIdx
);

  logic                w_aValid;
  logic [ID_WIDTH-1:0] w_aIdx;
  logic                w_bFound;
  logic [ID_WIDTH-1:0] w_bIdx;

  always_comb begin
    logic [ID_WIDTH-1:0] idx;
    idx      = '0;
    w_aValid = 1'b0;
    w_aIdx   = '0;
    w_bFound = 1'b0;
    w_bIdx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_WIDTH'((int'(i_ptr) + k) % N_REQ);
      if (i_req[idx]) begin
        if (!w_aValid) begin
          w_aValid = 1'b1;
          w_aIdx   = idx;
        end else if (!w_bFound) begin
          w_bFound = 1'b1;
          w_bIdx   = idx;
        end
      end
    end
  end

  // The mask only cancels B; it never promotes a later requester into B's slot.
  assign o_aValid = w_aValid;
  assign o_aIdx   = w_aIdx;
  assign o_bValid = w_bFound && !i_blockB[w_bIdx];
  assign o_bIdx   = w_bIdx;

endmodule

// File: rtl/meduram_port_arbiter.sv
// Shares a 2-write/2-read RAM between N_REQ requesters: round-robin picks two
// writes and two reads per cycle and routes read data back by requester id.
module meduram_port_arbiter
  import meduram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 2 ** ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [N_REQ-1:0]            wr_valid,
  output logic [N_REQ-1:0]            wr_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wr_data,
  input  logic [N_REQ-1:0]            rd_valid,
  output logic [N_REQ-1:0]            rd_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [N_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic                        wren1,
  output logic                        wren2,
  output logic [ADDR_WIDTH-1:0]       wraddr1,
  output logic [ADDR_WIDTH-1:0]       wraddr2,
  output logic [DATA_WIDTH-1:0]       wrdata1,
  output logic [DATA_WIDTH-1:0]       wrdata2,
  output logic                        rden1,
  output logic                        rden2,
  output logic [ADDR_WIDTH-1:0]       rdaddr1,
  output logic [ADDR_WIDTH-1:0]       rdaddr2,
  input  logic [DATA_WIDTH-1:0]       rddata1,
  input  logic [DATA_WIDTH-1:0]       rddata2
);

  localparam int ID_WIDTH = idWidth(N_REQ);

  if (N_REQ < 2 || RD_LATENCY < 1 || ID_WIDTH > TAG_ID_WIDTH ||
      RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_badParams
    $error("meduram_port_arbiter: unsupported parameter combination");
  end

  logic [ADDR_WIDTH-1:0] w_wrAddr [N_REQ];
  logic [DATA_WIDTH-1:0] w_wrData [N_REQ];
  logic [ADDR_WIDTH-1:0] w_rdAddr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_wrAddr[g] = wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wrData[g] = wr_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_rdAddr[g] = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  logic [ID_WIDTH-1:0] r_wrPtr, r_rdPtr;
  logic                w_wrAValid, w_wrBValid, w_rdAValid, w_rdBValid;
  logic [ID_WIDTH-1:0] w_wrAIdx, w_wrBIdx, w_rdAIdx, w_rdBIdx;
  logic [N_REQ-1:0]    w_wrBlock;
  logic                w_wrGntA, w_wrGntB, w_rdGntA, w_rdGntB;

  // A second write to the address port 1 is writing must wait a cycle.
  always_comb begin
    w_wrBlock = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_wrBlock[i] = (w_wrAddr[i] == w_wrAddr[w_wrAIdx]);
    end
  end

  meduram_rr_pick2 #(.N_REQ(N_REQ), .ID_WIDTH(ID_WIDTH)) u_wrPick (
    .i_req    (wr_valid),
    .i_ptr    (r_wrPtr),
    .i_blockB (w_wrBlock),
    .o_aValid (w_wrAValid),
    .o_aIdx   (w_wrAIdx),
    .o_bValid (w_wrBValid),
    .o_bIdx   (w_wrBIdx)
  );

  meduram_rr_pick2 #(.N_REQ(N_REQ), .ID_WIDTH(ID_WIDTH)) u_rdPick (
    .i_req    (rd_valid),
    .i_ptr    (r_rdPtr),
    .i_blockB ({N_REQ{1'b0}}),
    .o_aValid (w_rdAValid),
    .o_aIdx   (w_rdAIdx),
    .o_bValid (w_rdBValid),
    .o_bIdx   (w_rdBIdx)
  );

  assign w_wrGntA = w_wrAValid && !areset;
  assign w_wrGntB = w_wrBValid && !areset;
  assign w_rdGntA = w_rdAValid && !areset;
  assign w_rdGntB = w_rdBValid && !areset;

  always_comb begin
    wr_ready = '0;
    rd_ready = '0;
    if (w_wrGntA) wr_ready[w_wrAIdx] = 1'b1;
    if (w_wrGntB) wr_ready[w_wrBIdx] = 1'b1;
    if (w_rdGntA) rd_ready[w_rdAIdx] = 1'b1;
    if (w_rdGntB) rd_ready[w_rdBIdx] = 1'b1;
  end

  always_comb begin
    wren1   = w_wrGntA;
    wren2   = w_wrGntB;
    rden1   = w_rdGntA;
    rden2   = w_rdGntB;
    wraddr1 = '0;
    wrdata1 = '0;
    wraddr2 = '0;
    wrdata2 = '0;
    rdaddr1 = '0;
    rdaddr2 = '0;
    if (w_wrGntA) begin
      wraddr1 = w_wrAddr[w_wrAIdx];
      wrdata1 = w_wrData[w_wrAIdx];
    end
    if (w_wrGntB) begin
      wraddr2 = w_wrAddr[w_wrBIdx];
      wrdata2 = w_wrData[w_wrBIdx];
    end
    if (w_rdGntA) rdaddr1 = w_rdAddr[w_rdAIdx];
    if (w_rdGntB) rdaddr2 = w_rdAddr[w_rdBIdx];
  end

  function automatic logic [ID_WIDTH-1:0] nextIdx(input logic [ID_WIDTH-1:0] idx);
    return (int'(idx) >= N_REQ - 1) ? '0 : idx + ID_WIDTH'(1);
  endfunction

  // Pointers move just past the last requester actually granted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wrGntB)      r_wrPtr <= nextIdx(w_wrBIdx);
      else if (w_wrGntA) r_wrPtr <= nextIdx(w_wrAIdx);
      if (w_rdGntB)      r_rdPtr <= nextIdx(w_rdBIdx);
      else if (w_rdGntA) r_rdPtr <= nextIdx(w_rdAIdx);
    end
  end

  tag_t r_tag1 [RD_LATENCY];
  tag_t r_tag2 [RD_LATENCY];
  tag_t w_tag1In, w_tag2In, w_tag1Out, w_tag2Out;

  always_comb begin
    w_tag1In.en = w_rdGntA;
    w_tag1In.id = TAG_ID_WIDTH'(w_rdAIdx);
    w_tag2In.en = w_rdGntB;
    w_tag2In.id = TAG_ID_WIDTH'(w_rdBIdx);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        r_tag1[s] <= '0;
        r_tag2[s] <= '0;
      end
    end else begin
      r_tag1[0] <= w_tag1In;
      r_tag2[0] <= w_tag2In;
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_tag1[s] <= r_tag1[s-1];
        r_tag2[s] <= r_tag2[s-1];
      end
    end
  end

  assign w_tag1Out = r_tag1[RD_LATENCY-1];
  assign w_tag2Out = r_tag2[RD_LATENCY-1];

  logic [N_REQ-1:0]      w_hit1, w_hit2;
  logic [DATA_WIDTH-1:0] w_rspData [N_REQ];
  logic [DATA_WIDTH-1:0] r_rspHold [N_REQ];

  // Lanes without a strobe keep presenting the last data they received.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_hit1[i]    = w_tag1Out.en && (w_tag1Out.id == TAG_ID_WIDTH'(i));
      w_hit2[i]    = w_tag2Out.en && (w_tag2Out.id == TAG_ID_WIDTH'(i));
      w_rspData[i] = w_hit1[i] ? rddata1 : (w_hit2[i] ? rddata2 : r_rspHold[i]);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N_REQ; i++) r_rspHold[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) r_rspHold[i] <= w_rspData[i];
    end
  end

  assign rsp_valid = w_hit1 | w_hit2;

  for (genvar g = 0; g < N_REQ; g++) begin : g_pack
    assign rsp_data[g*DATA_WIDTH +: DATA_WIDTH] = w_rspData[g];
  end

endmodule

// File: tb/tb_meduram_port_arbiter.sv
// Bench for meduram_port_arbiter: behavioural RAM, queue-based reference
// model, directed scenarios followed by randomized traffic.
module tb_meduram_port_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic            aclk, areset;
  logic [N-1:0]    wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*DW-1:0] wr_data, rsp_data;
  logic            wren1, wren2, rden1, rden2;
  logic [AW-1:0]   wraddr1, wraddr2, rdaddr1, rdaddr2;
  logic [DW-1:0]   wrdata1, wrdata2, rddata1, rddata2;

  int checks = 0;
  int errors = 0;

  meduram_port_arbiter #(
    .ADDR_WIDTH(AW), .RAM_DEPTH(256), .DATA_WIDTH(DW), .N_REQ(N), .RD_LATENCY(LAT)
  ) dut (
    .aclk(aclk), .areset(areset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wren1(wren1), .wren2(wren2), .wraddr1(wraddr1), .wraddr2(wraddr2),
    .wrdata1(wrdata1), .wrdata2(wrdata2),
    .rden1(rden1), .rden2(rden2), .rdaddr1(rdaddr1), .rdaddr2(rdaddr2),
    .rddata1(rddata1), .rddata2(rddata2)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Behavioural 2W/2R RAM: reads see pre-write contents, data appears LAT cycles later.
  logic [DW-1:0] ram   [256] = '{default: '0};
  logic [DW-1:0] pipe1 [LAT] = '{default: '0};
  logic [DW-1:0] pipe2 [LAT] = '{default: '0};

  always @(posedge aclk) begin
    if (rden1) pipe1[0] <= ram[rdaddr1];
    if (rden2) pipe2[0] <= ram[rdaddr2];
    for (int s = 1; s < LAT; s++) begin
      pipe1[s] <= pipe1[s-1];
      pipe2[s] <= pipe2[s-1];
    end
    if (wren1) ram[wraddr1] <= wrdata1;
    if (wren2) ram[wraddr2] <= wrdata2;
  end

  assign rddata1 = pipe1[LAT-1];
  assign rddata2 = pipe2[LAT-1];

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          pendQ[$];
  logic [DW-1:0] mMem  [256] = '{default: '0};
  logic [DW-1:0] mHold [N]   = '{default: '0};
  int            mWrPtr = 0;
  int            mRdPtr = 0;
  int            cyc = 0;
  logic [N-1:0]  mWrGnt = '0;
  logic [N-1:0]  mRdGnt = '0;

  function automatic logic [AW-1:0] wrAddrOf(input int i);
    return wr_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wrDataOf(input int i);
    return wr_data[i*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] rdAddrOf(input int i);
    return rd_addr[i*AW +: AW];
  endfunction

  // Valid requesters listed in rotation order from the pointer; the first two win.
  function automatic void pickTwo(input logic [N-1:0] v, input int ptr, output int a, output int b);
    int order[$];
    for (int d = 0; d < N; d++) begin
      if (v[(ptr + d) % N]) order.push_back((ptr + d) % N);
    end
    a = (order.size() > 0) ? order[0] : -1;
    b = (order.size() > 1) ? order[1] : -1;
  endfunction

  function automatic logic [AW+DW:0] busWr(input int i);
    return (i < 0) ? '0 : {1'b1, wrAddrOf(i), wrDataOf(i)};
  endfunction

  function automatic logic [AW:0] busRd(input int i);
    return (i < 0) ? '0 : {1'b1, rdAddrOf(i)};
  endfunction

  task automatic checkEq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int wa, wb, ra, rb;
    logic [N-1:0]    eWr, eRd, eRsp;
    logic [N*DW-1:0] eRspD;
    rsp_t            keep[$];
    rsp_t            r;
    wa = -1; wb = -1; ra = -1; rb = -1;
    if (areset) begin
      pendQ.delete();
      for (int i = 0; i < N; i++) mHold[i] = '0;
      mWrPtr = 0;
      mRdPtr = 0;
    end else begin
      pickTwo(wr_valid, mWrPtr, wa, wb);
      if (wb >= 0 && wrAddrOf(wb) == wrAddrOf(wa)) wb = -1;
      pickTwo(rd_valid, mRdPtr, ra, rb);
    end
    eWr = '0;
    eRd = '0;
    if (wa >= 0) eWr[wa] = 1'b1;
    if (wb >= 0) eWr[wb] = 1'b1;
    if (ra >= 0) eRd[ra] = 1'b1;
    if (rb >= 0) eRd[rb] = 1'b1;
    eRsp = '0;
    foreach (pendQ[k]) begin
      if (pendQ[k].due == cyc) begin
        eRsp[pendQ[k].id] = 1'b1;
        mHold[pendQ[k].id] = pendQ[k].data;
      end
    end
    for (int i = 0; i < N; i++) eRspD[i*DW +: DW] = mHold[i];
    checkEq("wr_ready", wr_ready, eWr);
    checkEq("rd_ready", rd_ready, eRd);
    checkEq("ramWrBus", {wren1, wraddr1, wrdata1, wren2, wraddr2, wrdata2}, {busWr(wa), busWr(wb)});
    checkEq("ramRdBus", {rden1, rdaddr1, rden2, rdaddr2}, {busRd(ra), busRd(rb)});
    checkEq("rsp_valid", rsp_valid, eRsp);
    checkEq("rsp_data", rsp_data, eRspD);
    if (!areset) begin
      if (ra >= 0) begin
        r.due = cyc + LAT; r.id = ra; r.data = mMem[rdAddrOf(ra)];
        pendQ.push_back(r);
      end
      if (rb >= 0) begin
        r.due = cyc + LAT; r.id = rb; r.data = mMem[rdAddrOf(rb)];
        pendQ.push_back(r);
      end
      if (wa >= 0) mMem[wrAddrOf(wa)] = wrDataOf(wa);
      if (wb >= 0) mMem[wrAddrOf(wb)] = wrDataOf(wb);
      if (wb >= 0)      mWrPtr = (wb + 1) % N;
      else if (wa >= 0) mWrPtr = (wa + 1) % N;
      if (rb >= 0)      mRdPtr = (rb + 1) % N;
      else if (ra >= 0) mRdPtr = (ra + 1) % N;
    end
    foreach (pendQ[k]) if (pendQ[k].due != cyc) keep.push_back(pendQ[k]);
    pendQ  = keep;
    mWrGnt = eWr;
    mRdGnt = eRd;
    cyc++;
  endtask

  task automatic applyStimulus();
    #1;
    checkOutput();
    @(negedge aclk);
  endtask

  task automatic setWr(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid[i]        = v;
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic setRd(input int i, input bit v, input logic [AW-1:0] a);
    rd_valid[i]         = v;
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic clearReqs();
    wr_valid = '0;
    rd_valid = '0;
  endtask

  task automatic doReset();
    areset = 1'b1;
    #1;
    checkEq("rst_ctrlZero", {wr_ready, rd_ready, wren1, wren2, rden1, rden2, rsp_valid}, '0);
    checkEq("rst_rspDataZero", rsp_data, '0);
    applyStimulus();
    applyStimulus();
    areset = 1'b0;
  endtask

  task automatic randomRefill(input bit keepRd3);
    for (int i = 0; i < N; i++) begin
      if (mWrGnt[i] || !wr_valid[i])
        setWr(i, $urandom_range(0, 2) != 0, AW'($urandom_range(0, 15)), $urandom);
      if (keepRd3 && i == 3) begin
        if (mRdGnt[i]) setRd(i, 1'b1, AW'($urandom_range(0, 15)));
      end else if (mRdGnt[i] || !rd_valid[i]) begin
        setRd(i, $urandom_range(0, 1) != 0, AW'($urandom_range(0, 15)));
      end
    end
  endtask

  initial begin
    int missRun;
    areset   = 1'b1;
    wr_valid = '1;
    rd_valid = '1;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    $display("[TB] starting meduram_port_arbiter bench");
    @(negedge aclk);
    doReset();
    clearReqs();

    // single write then read-back through requester 0
    setWr(0, 1'b1, 8'd100, 32'h0000BEEF);
    #1 checkEq("t1_wren1", wren1, 1'b1);
    applyStimulus();
    clearReqs();
    setRd(0, 1'b1, 8'd100);
    #1 checkEq("t1_rdReady", rd_ready, 4'b0001);
    applyStimulus();
    clearReqs();
    repeat (LAT - 1) applyStimulus();
    #1 checkEq("t1_rspValid", rsp_valid, 4'b0001);
    checkEq("t1_rspData", rsp_data[31:0], 32'h0000BEEF);
    applyStimulus();

    // four writers held continuously: pairs alternate (0,1) then (2,3)
    doReset();
    for (int i = 0; i < N; i++) setWr(i, 1'b1, AW'(10 + i), 32'h1000 + i);
    for (int k = 0; k < 6; k++) begin
      #1 checkEq("t2_pairs", wr_ready, (k % 2 == 0) ? 4'b0011 : 4'b1100);
      applyStimulus();
    end
    clearReqs();

    // same-address collision: port 2 waits a cycle
    doReset();
    setWr(1, 1'b1, 8'd34, 32'h00001234);
    setWr(2, 1'b1, 8'd34, 32'h00005678);
    #1 checkEq("t3_cyc1Ready", wr_ready, 4'b0010);
    checkEq("t3_cyc1Wren2", wren2, 1'b0);
    applyStimulus();
    wr_valid[1] = 1'b0;
    #1 checkEq("t3_cyc2Ready", wr_ready, 4'b0100);
    applyStimulus();
    clearReqs();
    setRd(0, 1'b1, 8'd34);
    applyStimulus();
    clearReqs();
    repeat (LAT - 1) applyStimulus();
    #1 checkEq("t3_rspData", rsp_data[31:0], 32'h00005678);
    applyStimulus();

    // two simultaneous reads on different lanes
    setWr(0, 1'b1, 8'd0, 32'h00009876);
    setWr(3, 1'b1, 8'd255, 32'h0000B00B);
    applyStimulus();
    clearReqs();
    setRd(0, 1'b1, 8'd0);
    setRd(3, 1'b1, 8'd255);
    applyStimulus();
    clearReqs();
    repeat (LAT - 1) applyStimulus();
    #1 checkEq("t4_rspValid", rsp_valid, 4'b1001);
    checkEq("t4_rspData0", rsp_data[31:0], 32'h00009876);
    checkEq("t4_rspData3", rsp_data[127:96], 32'h0000B00B);
    applyStimulus();

    // reset while a read is still in flight drops the response
    setRd(1, 1'b1, 8'd34);
    applyStimulus();
    clearReqs();
    applyStimulus();
    doReset();
    for (int k = 0; k < LAT + 2; k++) begin
      #1 checkEq("t5_noRsp", rsp_valid, 4'b0000);
      applyStimulus();
    end
    for (int i = 0; i < N; i++) begin
      setWr(i, 1'b1, AW'(40 + i), 32'hA0 + i);
      setRd(i, 1'b1, AW'(40 + i));
    end
    #1 checkEq("t5_wrPtrZero", wr_ready, 4'b0011);
    checkEq("t5_rdPtrZero", rd_ready, 4'b0011);
    applyStimulus();
    clearReqs();

    // requester 3 reads continuously while the others come and go
    setRd(3, 1'b1, AW'($urandom_range(0, 15)));
    missRun = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (rd_ready[3]) missRun = 0;
      else missRun++;
      checkEq("t6_noStarve", (missRun <= 1), 1'b1);
      applyStimulus();
      randomRefill(1'b1);
    end

    // open randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      randomRefill(1'b0);
      applyStimulus();
    end
    clearReqs();
    repeat (LAT + 1) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
